riscv_dcache: RTL and testbench

RISCV_DCACHE -- requirements
Module: riscv_dcache

---
 rtl/riscv_cache_pkg.sv | 25 ++
 rtl/riscv_dcache_if.sv | 42 ++++
 rtl/riscv_dcache_line_store.sv | 80 ++++++++
 rtl/riscv_dcache.sv | 135 +++++++++++++
 tb/tb_riscv_dcache.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_cache_pkg.sv
// Shared constants for the direct-mapped write-back data cache: default geometry,
// derived address-field widths and the controller state encoding.
package riscv_cache_pkg;

  localparam int unsigned ADDR_W             = 30;
  localparam int unsigned WORD_W             = 64;
  localparam int unsigned NUM_LINES_DEF      = 8;
  localparam int unsigned WORDS_PER_LINE_DEF = 4;

  localparam int unsigned OFFSET_W_DEF    = $clog2(WORDS_PER_LINE_DEF);
  localparam int unsigned INDEX_W_DEF     = $clog2(NUM_LINES_DEF);
  localparam int unsigned TAG_W_DEF       = ADDR_W - INDEX_W_DEF - OFFSET_W_DEF;
  localparam int unsigned LINE_W_DEF      = WORD_W * WORDS_PER_LINE_DEF;
  localparam int unsigned LINE_ADDR_W_DEF = ADDR_W - OFFSET_W_DEF;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  // Width of a line address for a given line size.
  function automatic int unsigned line_addr_w(input int unsigned words_per_line);
    return ADDR_W - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/riscv_dcache_if.sv
// Processor-side and memory-side buses of the data cache. The processor bus is
// mastered by the core, the memory bus is mastered by the cache.
interface riscv_dcache_proc_if import riscv_cache_pkg::*;;
  logic              proc_read;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0] proc_wdata;
  logic [WORD_W-1:0] proc_rdata;
  logic              proc_stall;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall
  );
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_rdata, proc_stall
  );
endinterface

interface riscv_dcache_mem_if import riscv_cache_pkg::*; #(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
);
  localparam int unsigned LINE_W      = WORD_W * WORDS_PER_LINE;
  localparam int unsigned LINE_ADDR_W = line_addr_w(WORDS_PER_LINE);

  logic                   mem_read;
  logic                   mem_write;
  logic [LINE_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]      mem_wdata;
  logic [LINE_W-1:0]      mem_rdata;
  logic                   mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/riscv_dcache_line_store.sv
// Line storage of the direct-mapped cache: valid/dirty/tag per line and one data
// column per word, with a one-word store port, a full-line fill port and async read.
module riscv_dcache_line_store import riscv_cache_pkg::*; #(
  parameter  int unsigned NUM_LINES      = NUM_LINES_DEF,
  parameter  int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  localparam int unsigned INDEX_W        = $clog2(NUM_LINES),
  localparam int unsigned OFFSET_W       = $clog2(WORDS_PER_LINE),
  localparam int unsigned TAG_W          = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic                clk,
  input  logic                srst_i,

  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [WORD_W-1:0]   rd_word_o,
  output logic [LINE_W-1:0]   rd_line_o,

  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [WORD_W-1:0]   wr_data_i,

  input  logic                fill_en_i,
  input  logic [INDEX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [LINE_W-1:0]   fill_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [WORD_W-1:0]    rd_words [WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (srst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i] <= fill_tag_i;
    end
  end

  // One storage column per word so a store touches a single column.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      logic [WORD_W-1:0] col_q [NUM_LINES];

      always_ff @(posedge clk) begin
        if (fill_en_i) begin
          col_q[fill_idx_i] <= fill_data_i[gi*WORD_W +: WORD_W];
        end else if (wr_en_i && (wr_off_i == OFFSET_W'(gi))) begin
          col_q[wr_idx_i] <= wr_data_i;
        end
      end

      assign rd_words[gi]                    = col_q[rd_idx_i];
      assign rd_line_o[gi*WORD_W +: WORD_W]  = col_q[rd_idx_i];
    end
  endgenerate

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_word_o  = rd_words[rd_off_i];

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped write-back, write-allocate data cache. rst_n is an active-high
// synchronous reset; hits complete combinationally, misses stall through WB/ALLOC.
module riscv_dcache import riscv_cache_pkg::*; #(
  parameter int unsigned NUM_LINES      = NUM_LINES_DEF,
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  riscv_dcache_proc_if.slave  proc,
  riscv_dcache_mem_if.master  mem
);

  localparam int unsigned INDEX_W     = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_W    = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W      = WORD_W * WORDS_PER_LINE;
  localparam int unsigned LINE_ADDR_W = TAG_W + INDEX_W;

  logic [1:0]          state_q, state_d;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req;
  logic                hit;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [WORD_W-1:0]   rd_word;
  logic [LINE_W-1:0]   rd_line;

  logic                wr_en;
  logic                fill_en;

  logic                stall;
  logic [WORD_W-1:0]   rdata;
  logic                mread;
  logic                mwrite;
  logic [LINE_ADDR_W-1:0] maddr;
  logic [LINE_W-1:0]   mwdata;

  assign req_off = proc.proc_addr[OFFSET_W-1:0];
  assign req_idx = proc.proc_addr[OFFSET_W +: INDEX_W];
  assign req_tag = proc.proc_addr[ADDR_W-1 -: TAG_W];
  assign req     = proc.proc_read | proc.proc_write;
  assign hit     = req && rd_valid && (rd_tag == req_tag);

  // A simultaneous read and write is a store; the read port still shows the old word.
  assign wr_en   = !rst_n && (state_q == ST_IDLE) && hit && proc.proc_write;
  assign fill_en = !rst_n && (state_q == ST_ALLOCATE) && mem.mem_ready;

  riscv_dcache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_store (
    .clk         (clk),
    .srst_i      (rst_n),
    .rd_idx_i    (req_idx),
    .rd_off_i    (req_off),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .rd_line_o   (rd_line),
    .wr_en_i     (wr_en),
    .wr_idx_i    (req_idx),
    .wr_off_i    (req_off),
    .wr_data_i   (proc.proc_wdata),
    .fill_en_i   (fill_en),
    .fill_idx_i  (req_idx),
    .fill_tag_i  (req_tag),
    .fill_data_i (mem.mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: if (mem.mem_ready) state_d = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem.mem_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are quiet while reset is asserted so an abandoned transfer drops at once.
  always_comb begin
    stall  = 1'b0;
    rdata  = '0;
    mread  = 1'b0;
    mwrite = 1'b0;
    maddr  = '0;
    mwdata = '0;
    if (!rst_n) begin
      case (state_q)
        ST_IDLE: begin
          stall = req && !hit;
          if (hit && proc.proc_read) rdata = rd_word;
        end
        ST_WRITEBACK: begin
          stall  = 1'b1;
          mwrite = 1'b1;
          maddr  = {rd_tag, req_idx};
          mwdata = rd_line;
        end
        ST_ALLOCATE: begin
          stall = 1'b1;
          mread = 1'b1;
          maddr = {req_tag, req_idx};
        end
        default: stall = 1'b1;
      endcase
    end
  end

  assign proc.proc_stall = stall;
  assign proc.proc_rdata = rdata;
  assign mem.mem_read    = mread;
  assign mem.mem_write   = mwrite;
  assign mem.mem_addr    = maddr;
  assign mem.mem_wdata   = mwdata;

endmodule

// File: tb/tb_riscv_dcache.sv
// Directed plus random accesses against a line-level cache/memory model.
module tb_riscv_dcache;
  import riscv_cache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  riscv_dcache_proc_if proc_bus ();
  riscv_dcache_mem_if #(.WORDS_PER_LINE(4)) mem_bus ();

  riscv_dcache #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .proc  (proc_bus.slave),
    .mem   (mem_bus.master)
  );

  // Reference state: what each cache slot holds, and the backing memory contents.
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [255:0] m_line  [8];
  logic [255:0] mem_m   [logic [27:0]];

  int checks = 0;
  int errors = 0;

  function automatic logic [255:0] mem_get(input logic [27:0] la);
    logic [255:0] line;
    logic [3:0]   wn;
    if (mem_m.exists(la)) return mem_m[la];
    for (int w = 0; w < 4; w++) begin
      wn = 4'(w);
      line[w*64 +: 64] = {4'h5, la, 28'd0, wn};
    end
    return line;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    proc_bus.proc_read  = 1'b0;
    proc_bus.proc_write = 1'b0;
    mem_bus.mem_ready   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [29:0] addr,
                           input logic [63:0] wdata, input int waits, input string tag);
    logic [2:0]   idx;
    logic [24:0]  t;
    int           o;
    logic         hit, exp_wb, done;
    logic [27:0]  wb_addr, fill_addr;
    logic [255:0] wb_line, fill_line;
    logic [63:0]  exp_rdata;
    int n_tx, exp_stall, stall_n, wr_cyc, rd_cyc, wb_n, fill_n, tx_cnt, guard;

    idx       = addr[4:2];
    t         = addr[29:5];
    o         = int'(addr[1:0]);
    hit       = m_valid[idx] && (m_tag[idx] == t);
    exp_wb    = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], idx};
    wb_line   = m_line[idx];
    fill_addr = {t, idx};
    fill_line = '0;
    if (exp_wb) mem_m[wb_addr] = wb_line;
    if (!hit) begin
      fill_line    = mem_get(fill_addr);
      m_line[idx]  = fill_line;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = t;
    end
    exp_rdata = rd ? m_line[idx][o*64 +: 64] : 64'd0;
    if (wr) begin
      m_line[idx][o*64 +: 64] = wdata;
      m_dirty[idx] = 1'b1;
    end
    n_tx      = hit ? 0 : (exp_wb ? 2 : 1);
    exp_stall = hit ? 0 : 1 + n_tx * (waits + 1);

    @(posedge clk); #1;
    proc_bus.proc_read  = rd;
    proc_bus.proc_write = wr;
    proc_bus.proc_addr  = addr;
    proc_bus.proc_wdata = wdata;
    mem_bus.mem_ready   = 1'b0;
    stall_n = 0; wr_cyc = 0; rd_cyc = 0; wb_n = 0; fill_n = 0; tx_cnt = 0; guard = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (mem_bus.mem_ready) begin
        mem_bus.mem_ready = 1'b0;
        tx_cnt = 0;
      end
      chk({tag, ".mem_excl"}, 256'(mem_bus.mem_read & mem_bus.mem_write), 256'(0));
      if (!proc_bus.proc_stall) begin
        chk({tag, ".rdata"}, 256'(proc_bus.proc_rdata), 256'(exp_rdata));
        done = 1'b1;
      end else begin
        stall_n++;
        if (mem_bus.mem_write) begin
          if (tx_cnt == 0) wb_n++;
          wr_cyc++;
          chk({tag, ".wb_addr"}, 256'(mem_bus.mem_addr), 256'(wb_addr));
          chk({tag, ".wb_data"}, mem_bus.mem_wdata, wb_line);
        end else if (mem_bus.mem_read) begin
          if (tx_cnt == 0) fill_n++;
          rd_cyc++;
          chk({tag, ".fill_addr"}, 256'(mem_bus.mem_addr), 256'(fill_addr));
        end
        if (mem_bus.mem_write || mem_bus.mem_read) begin
          if (tx_cnt == waits) begin
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_rdata = mem_bus.mem_read ? fill_line : 256'd0;
          end
          tx_cnt++;
        end
        guard++;
        if (guard > 100) begin
          chk({tag, ".timeout"}, 256'(1), 256'(0));
          done = 1'b1;
        end
      end
    end
    chk({tag, ".stall_cycles"}, 256'(stall_n), 256'(exp_stall));
    chk({tag, ".wb_count"}, 256'(wb_n), 256'(exp_wb));
    chk({tag, ".fill_count"}, 256'(fill_n), 256'(hit ? 0 : 1));
    chk({tag, ".mem_write_cycles"}, 256'(wr_cyc), 256'(exp_wb ? waits + 1 : 0));
    chk({tag, ".mem_read_cycles"}, 256'(rd_cyc), 256'(hit ? 0 : waits + 1));
    $display("txn %s rd=%0d wr=%0d addr=%h waits=%0d hit=%0d wb=%0d stall=%0d rdata=%h",
             tag, rd, wr, addr, waits, hit, exp_wb, stall_n, proc_bus.proc_rdata);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    proc_bus.proc_read  = 1'b0;
    proc_bus.proc_write = 1'b0;
    mem_bus.mem_ready   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    logic        r, w;
    int          op;

    proc_bus.proc_read  = 1'b0;
    proc_bus.proc_write = 1'b0;
    proc_bus.proc_addr  = '0;
    proc_bus.proc_wdata = '0;
    mem_bus.mem_ready   = 1'b0;
    mem_bus.mem_rdata   = '0;
    mem_m[28'h4] = {4{64'hAAAA_AAAA_AAAA_AAAA}};

    apply_reset();
    @(negedge clk);
    chk("reset.stall",  256'(proc_bus.proc_stall), 256'(0));
    chk("reset.mread",  256'(mem_bus.mem_read),    256'(0));
    chk("reset.mwrite", 256'(mem_bus.mem_write),   256'(0));
    chk("reset.maddr",  256'(mem_bus.mem_addr),    256'(0));
    chk("reset.mwdata", mem_bus.mem_wdata,         256'(0));
    chk("reset.rdata",  256'(proc_bus.proc_rdata), 256'(0));

    // Stray ready pulse while idle must not disturb anything.
    @(posedge clk); #1; mem_bus.mem_ready = 1'b1;
    @(posedge clk); #1; mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready.mread", 256'(mem_bus.mem_read),    256'(0));
    chk("idle_ready.stall", 256'(proc_bus.proc_stall), 256'(0));

    do_access(1'b1, 1'b0, 30'h10, 64'd0, 3, "cold_read");
    do_access(1'b0, 1'b1, 30'h10, 64'h1234, 1, "hit_write");
    do_access(1'b1, 1'b0, 30'h10, 64'd0, 0, "hit_read");
    do_access(1'b1, 1'b0, 30'h30, 64'd0, 2, "dirty_conflict");
    do_access(1'b1, 1'b0, 30'h10, 64'd0, 1, "clean_conflict");
    do_access(1'b1, 1'b1, 30'h11, 64'hDEADBEEF_CAFEF00D, 0, "rw_hit");
    do_access(1'b1, 1'b0, 30'h11, 64'd0, 0, "rw_readback");
    go_idle();

    // Reset while a fill is outstanding.
    @(posedge clk); #1;
    proc_bus.proc_read = 1'b1;
    proc_bus.proc_addr = 30'h200;
    repeat (2) @(negedge clk);
    chk("rst_alloc.pre_mread", 256'(mem_bus.mem_read), 256'(1));
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_alloc.mread",  256'(mem_bus.mem_read),    256'(0));
    chk("rst_alloc.mwrite", 256'(mem_bus.mem_write),   256'(0));
    chk("rst_alloc.stall",  256'(proc_bus.proc_stall), 256'(1));
    proc_bus.proc_read = 1'b0;
    do_access(1'b1, 1'b0, 30'h200, 64'd0, 2, "rst_alloc_retry");
    do_access(1'b1, 1'b0, 30'h10, 64'd0, 0, "post_reset_cold");

    for (int i = 0; i < 80; i++) begin
      a  = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 3));
      r  = (op != 1);
      w  = (op == 1) || (op == 2);
      do_access(r, w, a, {$urandom, $urandom}, int'($urandom_range(0, 3)), "random");
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
